v_calc_in: RTL
==============

# v_calc_in

Input front-end for the four-digit calculator. Synchronises and debounces the five push-buttons and the eight slide switches, turns button presses into single-cycle events, and holds operands A and B and the selected operation in registers. Its outputs feed the calculator's arithmetic/display path in place of raw switch and button levels.

## Interface
- DEB_CYCLES, 20'd1_000_000: consecutive stable cycles needed before a debounced button level changes (10 ms at 100 MHz); minimum 2.
- CNT_W, 20: debounce counter width; must hold DEB_CYCLES.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sw  in  8  raw slide switches; sw[7] selects the target operand (0 = A, 1 = B), sw[6:0] is the value.
- btn  in  5  raw buttons; btn[0] = load, btn[1] = add, btn[2] = sub, btn[3] = mul, btn[4] = div/mod.
- a_o  out  7  registered operand A.
- b_o  out  7  registered operand B.
- op_o  out  3  registered operation: 0 none, 1 add, 2 sub, 3 mul, 4 div, 5 mod.
- ready_o  out  1  high while A, B and op are all valid.
- go_o  out  1  one-cycle pulse when the (A, B, op) tuple changes while ready_o is high or becomes high.
- err_o  out  1  high while op_o is 4 or 5 and b_o == 0.

## Operation
- Sync: sw and btn each pass through a 2-flop synchroniser.
- Debounce, per button: counter clears whenever the synced level equals the debounced level. Otherwise it increments. When it reaches DEB_CYCLES-1, the debounced level takes the synced level and the counter clears. Switches are synchronised only.
- Press event: one-cycle pulse on a debounced 0->1 transition. Releases generate nothing.
- Simultaneous press events: the lowest index wins; the others are discarded (not deferred).
- Load (btn[0]) writes sw[6:0] to A if sw[7]=0, otherwise to B, and sets that operand's valid bit.
- Clear: load while synced sw == 8'hFF clears A, B, op, both valid bits and the state, returning to EMPTY. No go_o.
- btn[1..3] set op to 1/2/3. btn[4] sets op to 4, or to 5 if op is already 4.
- FSM:
  - EMPTY: no valid bits. A load goes to PARTIAL.
  - PARTIAL: one or more of A, B or op is still missing. It goes to READY when all three become valid.
  - READY: ready_o=1. Loads and op changes stay in READY. Clear goes to EMPTY.
- go_o fires on entry to READY, and on any accepted event in READY. It fires even if the written value equals the old one.
- Reset values: a_o=0, b_o=0, op_o=0, ready_o=0, go_o=0, err_o=0, state EMPTY, debounced levels 0, counters 0.
- Reset mid-debounce or mid-event: the event is lost. No pulse is emitted after rst_n deasserts.

## Timing
- All outputs are registered.
- A raw button level held stable from edge k gives a press event registered at edge k+DEB_CYCLES+2. Registers, go_o and ready_o update at edge k+DEB_CYCLES+3.
- Glitches shorter than DEB_CYCLES cycles (after sync) produce no event.
- go_o is high for exactly one cycle per accepted event. Back-to-back events on consecutive debounced presses each give their own pulse.
- err_o and ready_o update in the same cycle as the register write that changes them.
- A load samples sw in the same cycle as the load event, using the synced value (2 cycles behind raw).

## Configuration
- V_CALC_IN_DEBOUNCE_EN defined: debounce counters are instantiated as described above.
- Not defined: debounced level = synced level, with no counters and DEB_CYCLES ignored. A button stable from edge k gives its event at edge k+2 and register updates at edge k+3. This mode is for simulation only.

## Test plan
- Reset: hold rst_n=0 with btn=5'b11111 and sw=8'hFF, then release. All outputs stay 0 and no go_o pulse occurs for 2×DEB_CYCLES cycles.
- Bounce: toggle btn[0] every DEB_CYCLES/2 cycles for 10 toggles, then hold high. Exactly one load occurs, at the cycle given in Timing, and a_o takes sw[6:0].
- Entry: load A=25 (sw=8'h19), load B=5 (sw=8'h85), press btn[3]. Result: a_o=25, b_o=5, op_o=3, ready_o=1, one go_o pulse.
- Div/mod and error: from READY with b_o=5, load B=0 (sw=8'h80), then press btn[4] twice. err_o=1, op_o goes 4 then 5, and go_o pulses three times.
- Simultaneous and clear: press btn[1] and btn[2] in the same cycle, giving op_o=1 only. Then load with sw=8'hFF: all outputs return to 0, state EMPTY, no go_o.
- With V_CALC_IN_DEBOUNCE_EN undefined: a 3-cycle btn[2] pulse gives op_o=2 three cycles after its first sampled edge.

Source files
------------

// File: rtl/v_calc_in.sv
// v_calc_in: calculator input front-end (sync, debounce, operand/op regs).
// Optional debounce counters: define V_CALC_IN_DEBOUNCE_EN.
module v_calc_in #(
  parameter int               CNT_W      = 20,
  parameter logic [CNT_W-1:0] DEB_CYCLES = 20'd1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic [4:0] btn,
  output logic [6:0] a_o,
  output logic [6:0] b_o,
  output logic [2:0] op_o,
  output logic       ready_o,
  output logic       go_o,
  output logic       err_o
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    READY   = 2'd2
  } st_t;

  logic [7:0] sw_s1, sw_s2;
  logic [4:0] btn_s1, btn_s2;
  logic [4:0] deb, deb_q, rise, ev;
  st_t        st_q, st_n;
  logic       av_q, bv_q, av_n, bv_n;
  logic [6:0] a_n, b_n;
  logic [2:0] op_n;
  logic       go_n, clr, all_v;

  // two-flop synchronisers for switches and buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

`ifdef V_CALC_IN_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_MAX = DEB_CYCLES - 1'b1;

  logic [CNT_W-1:0] cnt [5];

  // per-button counter; level follows sync only after a stable run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (btn_s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_MAX) begin
          deb[i] <= btn_s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign deb = btn_s2;
`endif

  // lowest-index rising edge wins, the rest are dropped
  assign rise = deb & ~deb_q;

  // press detection and single-event register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      ev    <= '0;
    end else begin
      deb_q <= deb;
      ev    <= rise & (~rise + 5'd1);
    end
  end

  assign clr = ev[0] && (sw_s2 == 8'hFF);

  // next operands, op, state and go for the current event
  always_comb begin
    a_n   = a_o;
    b_n   = b_o;
    op_n  = op_o;
    av_n  = av_q;
    bv_n  = bv_q;
    st_n  = st_q;
    go_n  = 1'b0;
    all_v = 1'b0;
    if (clr) begin
      a_n  = '0;
      b_n  = '0;
      op_n = '0;
      av_n = 1'b0;
      bv_n = 1'b0;
      st_n = EMPTY;
    end else begin
      unique case (1'b1)
        ev[0]: begin
          if (sw_s2[7]) begin
            b_n  = sw_s2[6:0];
            bv_n = 1'b1;
          end else begin
            a_n  = sw_s2[6:0];
            av_n = 1'b1;
          end
        end
        ev[1]: op_n = 3'd1;
        ev[2]: op_n = 3'd2;
        ev[3]: op_n = 3'd3;
        ev[4]: op_n = (op_o == 3'd4) ? 3'd5 : 3'd4;
        default: ;
      endcase
      all_v = av_n && bv_n && (op_n != 3'd0);
      unique case (st_q)
        EMPTY:   if (|ev) st_n = all_v ? READY : PARTIAL;
        PARTIAL: if (all_v) st_n = READY;
        READY:   st_n = READY;
        default: st_n = EMPTY;
      endcase
      go_n = (|ev) && (st_n == READY);
    end
  end

  // state, operand registers and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= EMPTY;
      a_o     <= '0;
      b_o     <= '0;
      op_o    <= '0;
      av_q    <= 1'b0;
      bv_q    <= 1'b0;
      ready_o <= 1'b0;
      go_o    <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      st_q    <= st_n;
      a_o     <= a_n;
      b_o     <= b_n;
      op_o    <= op_n;
      av_q    <= av_n;
      bv_q    <= bv_n;
      ready_o <= (st_n == READY);
      go_o    <= go_n;
      err_o   <= ((op_n == 3'd4) || (op_n == 3'd5)) && (b_n == 7'd0);
    end
  end

endmodule
